// File: rtl/integer_rs_pkg.sv
// integer_rs_pkg
//   Shared definitions for the reservation stations:
//   - RS_* destination codes that dispatch uses to tag packets
//   - INT_PKT_W and int_rs_entry_t, the layout of one integer packet
//     {aluop[72:69], rd[68:64], op1[63:32], op2[31:0]}
package integer_rs_pkg;

   localparam int INT_PKT_W = 73;

   localparam logic [2:0] RS_INTEGER    = 3'd1;
   localparam logic [2:0] RS_LOAD_STORE = 3'd2;
   localparam logic [2:0] RS_BRANCH     = 3'd3;

   typedef struct packed {
      logic [3:0]  aluop;   // {funct3, funct7[5] or 0}
      logic [4:0]  rd;
      logic [31:0] op1;
      logic [31:0] op2;
   } int_rs_entry_t;

endpackage

// File: rtl/integer_rs_if.sv
// integer_rs_if
//   Bundles the dispatch-side and ALU-side signals of the integer
//   reservation station.
//   Handshakes:
//   - Dispatch: a packet transfers on a clock edge where in_valid=1,
//     rs_destination=RS_INTEGER, full=0 and kill=0. A refused packet is
//     held stable by dispatch and retried.
//   - ALU: the head transfers on a clock edge where issue_valid=1,
//     issue_ready=1 and kill=0. issue_* stays stable while issue_ready=0.
//   Modports:
//   - slave:  the reservation station
//   - master: dispatch + ALU (the environment)
interface integer_rs_if #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1)
);
   import integer_rs_pkg::*;

   logic                 kill;
   logic                 in_valid;
   logic [2:0]           rs_destination;
   logic [INT_PKT_W-1:0] rs_integer;
   logic                 full;
   logic [CW-1:0]        count;
   logic                 issue_valid;
   logic                 issue_ready;
   logic [3:0]           issue_aluop;
   logic [4:0]           issue_rd;
   logic [31:0]          issue_op1;
   logic [31:0]          issue_op2;

   modport slave (
      input  kill, in_valid, rs_destination, rs_integer, issue_ready,
      output full, count, issue_valid, issue_aluop, issue_rd, issue_op1, issue_op2
   );

   modport master (
      output kill, in_valid, rs_destination, rs_integer, issue_ready,
      input  full, count, issue_valid, issue_aluop, issue_rd, issue_op1, issue_op2
   );
endinterface

// File: rtl/integer_rs_queue_ctrl.sv
// rs_queue_ctrl
//   Pointer/occupancy control for an in-order reservation-station queue.
//   It owns no storage, so every station can reuse it.
//   Ports:
//     clk, reset    clock, asynchronous active-high reset
//     i_kill        synchronous flush of head/tail/count
//     i_push_req    a packet for this station is offered
//     i_pop_req     consumer ready for the head entry
//     o_acc         write the offered packet at o_tail this cycle
//     o_full        count == DEPTH
//     o_valid       count != 0
//     o_head        read pointer
//     o_tail        write pointer
//     o_count       occupancy
module rs_queue_ctrl #(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          i_kill,
   input  logic          i_push_req,
   input  logic          i_pop_req,
   output logic          o_acc,
   output logic          o_full,
   output logic          o_valid,
   output logic [AW-1:0] o_head,
   output logic [AW-1:0] o_tail,
   output logic [CW-1:0] o_count
);

   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_valid;
   logic          w_acc;
   logic          w_pop;

   // Full and empty are told apart only by count; the pointers simply wrap.
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_valid = (r_count != '0);
   // Full refuses even when a pop happens in the same cycle (no pass-through).
   assign w_acc   = i_push_req && !w_full && !i_kill;
   assign w_pop   = w_valid && i_pop_req && !i_kill;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else if (i_kill) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_acc) r_tail <= r_tail + AW'(1);
         if (w_pop) r_head <= r_head + AW'(1);
         case ({w_acc, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_acc   = w_acc;
   assign o_full  = w_full;
   assign o_valid = w_valid;
   assign o_head  = r_head;
   assign o_tail  = r_tail;
   assign o_count = r_count;

endmodule

// File: rtl/integer_rs.sv
// integer_rs
//   Integer reservation station: buffers RS_INTEGER packets from dispatch
//   in a circular FIFO and issues them in order to the integer ALU.
//   A packet accepted in cycle N is visible at issue in cycle N+1.
//   Ports:
//     clk    clock
//     reset  asynchronous active-high reset (issue_valid drops at once)
//     bus    integer_rs_if.slave: kill, dispatch packet in, full/count
//            back to dispatch, issue handshake and fields to the ALU
module integer_rs
   import integer_rs_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CW    = $clog2(DEPTH + 1),
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        reset,
   integer_rs_if.slave bus
);

   logic          w_push_req;
   logic          w_acc;
   logic          w_full;
   logic          w_valid;
   logic [AW-1:0] w_head;
   logic [AW-1:0] w_tail;
   logic [CW-1:0] w_count;
   int_rs_entry_t w_head_entry;

   // Entry storage is deliberately not reset; validity lives in the count.
   int_rs_entry_t r_mem [DEPTH];

   assign w_push_req = bus.in_valid && (bus.rs_destination == RS_INTEGER);

   rs_queue_ctrl #(
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_ctrl (
      .clk        (clk),
      .reset      (reset),
      .i_kill     (bus.kill),
      .i_push_req (w_push_req),
      .i_pop_req  (bus.issue_ready),
      .o_acc      (w_acc),
      .o_full     (w_full),
      .o_valid    (w_valid),
      .o_head     (w_head),
      .o_tail     (w_tail),
      .o_count    (w_count)
   );

   always_ff @(posedge clk) begin
      if (w_acc) r_mem[w_tail] <= bus.rs_integer;
   end

   // Stale storage must never leak out: fields are zero when nothing is valid.
   always_comb begin
      w_head_entry = '0;
      if (w_valid) w_head_entry = r_mem[w_head];
   end

   assign bus.full        = w_full;
   assign bus.count       = w_count;
   assign bus.issue_valid = w_valid;
   assign bus.issue_aluop = w_head_entry.aluop;
   assign bus.issue_rd    = w_head_entry.rd;
   assign bus.issue_op1   = w_head_entry.op1;
   assign bus.issue_op2   = w_head_entry.op2;

endmodule

// File: doc/integer_rs.md
Name: integer_rs

Overview:
- Integer reservation station: the receiving end of the dispatch stage's integer packet interface.
- Accepts 73-bit integer packets tagged for the integer unit and buffers them in an in-order circular queue.
- Issues them one per cycle to the integer ALU over a valid/ready handshake.
- Drives `full` back to dispatch as its stall source; `kill` flushes all contents.

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- CW, $clog2(DEPTH+1), width of the occupancy count.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- kill  input  1  synchronous flush of all entries (pipeline redirect)
- in_valid  input  1  dispatch packet present this cycle
- rs_destination  input  3  target-unit code; only RS_INTEGER is accepted
- rs_integer  input  73  packet {aluop[72:69], rd[68:64], op1[63:32], op2[31:0]}
- full  output  1  queue holds DEPTH entries; dispatch must stall
- count  output  CW  current occupancy
- issue_valid  output  1  head entry available to the ALU
- issue_ready  input  1  ALU consumes the head this cycle
- issue_aluop  output  4  head aluop: {funct3, funct7[5] or 0}
- issue_rd  output  5  head destination register
- issue_op1  output  32  head operand 1
- issue_op2  output  32  head operand 2 (register value or immediate)

Behaviour:
- Reset, asynchronous:
  - head, tail and count go to 0.
  - full=0, issue_valid=0, all issue_* data outputs 0.
  - Entry storage is not cleared.
- Accept: `acc = in_valid && rs_destination==RS_INTEGER && !full && !kill`.
  - On acc, the packet is written at tail and tail increments modulo DEPTH.
- Pop: `pop = issue_valid && issue_ready && !kill`.
  - On pop, head increments modulo DEPTH.
- Count update: count += acc − pop.
  - acc and pop in the same cycle leave count unchanged and are legal whenever 0<count<DEPTH.
- Latency: a packet accepted in cycle N is first visible at issue in cycle N+1. There is no empty-queue bypass.
- Full condition: full = (count==DEPTH).
  - When full, a packet is refused even if a pop occurs in the same cycle (no pass-through).
  - Dispatch holds the packet stable and retries.
- Refused packets: in_valid with a non-integer destination is ignored, with no state change.
- Issue outputs:
  - issue_valid = (count!=0).
  - issue_* data is driven from the head entry when issue_valid=1 and forced to 0 otherwise.
  - The head entry stays stable while issue_ready=0.
- Issue order: strict FIFO. rd==0 packets are queued and issued normally.
- Kill:
  - In the cycle kill is high, head, tail and count are cleared by the next edge.
  - kill overrides acc and pop in that cycle: no write, and the ALU must not treat an asserted issue_ready as consumption.
  - issue_valid may still be 1 during the kill cycle, and it is 0 in the following cycle.
- Pointer wrap: head and tail are log2(DEPTH) bits wide and wrap naturally. Full and empty are distinguished only by count.
- Reset mid-operation: all entries are lost immediately, and issue_valid drops asynchronously.

Decomposition:
- Shared package contents:
  - RS_INTEGER, RS_LOAD_STORE and RS_BRANCH codes.
  - Packed struct int_rs_entry_t {aluop[3:0], rd[4:0], op1[31:0], op2[31:0]}, whose width must equal 73.
  - INT_PKT_W=73.
- One natural sub-module, rs_queue_ctrl:
  - Contains the head/tail/count logic, acc/pop qualification, kill handling and full.
  - Parameterised on DEPTH so the load/store and branch stations reuse it.
  - Storage and output gating stay in integer_rs.

Test Plan:
- Single packet: after reset, enqueue {aluop=4'b0001, rd=5, op1=0x10, op2=0x20}.
  - Required: issue_valid=1 the next cycle with matching fields.
  - With issue_ready=1: count 1→0, and issue outputs return to 0.
- Fill to full: DEPTH=4, issue_ready=0, enqueue rd=1..5 on consecutive cycles.
  - Required: full=1 after the 4th packet, the 5th is refused and count=4.
  - Then issue_ready=1: issue rd order is 1,2,3,4.
- Simultaneous accept and pop with count=2: count stays 2 and the head advances.
  - With count=4 plus pop and in_valid: the packet is refused and count=3.
- Destination filter: in_valid=1 with rs_destination=RS_BRANCH and RS_LOAD_STORE.
  - Required: count unchanged, issue_valid stays 0.
- Kill flush: 3 entries queued, then kill=1 together with in_valid and issue_ready.
  - Required: next cycle count=0 and issue_valid=0.
  - The following enqueue issues first, confirming pointer consistency.
- Wrap and reset: run 10 enqueue/pop pairs at DEPTH=4 with data intact across the wrap.
  - Assert reset mid-stream: issue_valid drops asynchronously and count=0.
